// File: rtl/conv_window_accumulator.sv
// conv_window_accumulator: multi-channel windowed accumulator for the convolution datapath.
// Each channel sums TAP_COUNT accepted samples. The window result is then held in a
// result register and presented on a valid/ready output.
// Optional feature: define ACCUM_SAT_EN for saturating adds with sticky per-channel
// overflow flags. Without it, adds wrap and OutOvf is tied low.
module conv_window_accumulator #(
  parameter int WIDTH     = 32,
  parameter int IN_WIDTH  = 32,
  parameter int CHANNELS  = 4,
  parameter int TAP_COUNT = 9
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Clear,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic [CHANNELS*IN_WIDTH-1:0]  InData,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [CHANNELS*WIDTH-1:0]     OutData,
  output logic [CHANNELS-1:0]           OutOvf,
  output logic [$clog2(TAP_COUNT)-1:0]  TapCnt
);

  localparam int CNT_W = $clog2(TAP_COUNT);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAP_COUNT - 1);

  logic signed [WIDTH-1:0] sum_q    [CHANNELS];
  logic signed [WIDTH-1:0] sum_next [CHANNELS];
  logic signed [WIDTH-1:0] ext      [CHANNELS];
  logic signed [WIDTH-1:0] raw      [CHANNELS];
  logic                    last_tap;
  logic                    accept;

  // Only the final tap of a window stalls, and only while an older result is still unread.
  assign last_tap = (TapCnt == LAST_TAP);
  assign InReady  = !Clear && !(OutValid && !OutReady && last_tap);
  assign accept   = InValid && InReady;

  // Sign-extend each channel's sample and form the plain two's complement sum.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ext[c] = WIDTH'($signed(InData[c*IN_WIDTH +: IN_WIDTH]));
      raw[c] = sum_q[c] + ext[c];
    end
  end

`ifdef ACCUM_SAT_EN
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CHANNELS-1:0] add_ovf;
  logic [CHANNELS-1:0] ovf_q;

  // Detect signed overflow of this add and clamp toward the operands' common sign.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      add_ovf[c]  = (sum_q[c][WIDTH-1] == ext[c][WIDTH-1]) &&
                    (raw[c][WIDTH-1] != sum_q[c][WIDTH-1]);
      sum_next[c] = raw[c];
      if (add_ovf[c]) begin
        sum_next[c] = sum_q[c][WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
    end
  end

  // Overflow flags are sticky within a window and are handed to OutOvf with the result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ovf_q  <= '0;
      OutOvf <= '0;
    end else if (Clear) begin
      ovf_q <= '0;
    end else if (accept) begin
      if (last_tap) begin
        OutOvf <= ovf_q | add_ovf;
        ovf_q  <= '0;
      end else begin
        ovf_q <= ovf_q | add_ovf;
      end
    end
  end
`else
  // Wrapping arithmetic: the plain sum is the next value.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_next[c] = raw[c];
    end
  end

  assign OutOvf = '0;
`endif

  // Result valid: set by a completed window, dropped once downstream takes it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutValid <= 1'b0;
    end else if (accept && last_tap) begin
      OutValid <= 1'b1;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

  // Running sums, tap counter and result register. Clear only touches the window in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= '0;
      end
      TapCnt  <= '0;
      OutData <= '0;
    end else if (Clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= '0;
      end
      TapCnt <= '0;
    end else if (accept) begin
      if (last_tap) begin
        for (int c = 0; c < CHANNELS; c++) begin
          OutData[c*WIDTH +: WIDTH] <= sum_next[c];
          sum_q[c]                  <= '0;
        end
        TapCnt <= '0;
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          sum_q[c] <= sum_next[c];
        end
        TapCnt <= TapCnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/conv_window_accumulator.md
# conv_window_accumulator

Multi-channel, parametrised window accumulator for the convolution datapath. It sums `TAP_COUNT` accepted input samples per channel into a signed running total, then presents the per-channel window result on a valid/ready output. A double-buffered result register lets the next window accumulate while the previous result waits downstream. It generalises the single-channel 32-bit accumulator with width and channel parameters, windowed auto-restart, handshaking, synchronous clear and optional saturation.

## Interface
- `WIDTH`, 32: accumulator and result width per channel (signed).
- `IN_WIDTH`, 32: input sample width per channel (signed). Must satisfy `IN_WIDTH <= WIDTH`.
- `CHANNELS`, 4: number of independent channels.
- `TAP_COUNT`, 9: accepted samples per window, >= 2.
- `Clk`  in  1  sole clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Clear`  in  1  synchronous; discards the window in progress.
- `InValid`  in  1  input sample valid.
- `InReady`  out  1  block accepts the sample this cycle.
- `InData`  in  CHANNELS*IN_WIDTH  channel c is at bits [c*IN_WIDTH +: IN_WIDTH].
- `OutValid`  out  1  result available.
- `OutReady`  in  1  downstream accepts the result.
- `OutData`  out  CHANNELS*WIDTH  per-channel window sums, packed the same way as `InData`.
- `OutOvf`  out  CHANNELS  per-channel overflow flag for the presented window.
- `TapCnt`  out  clog2(TAP_COUNT)  taps accepted in the current window (status).

## Operation
- Accept occurs on a rising edge when `InValid && InReady`.
- On accept, each channel sign-extends its `IN_WIDTH` sample to `WIDTH` and adds it to its running sum. `TapCnt` increments.
- Final tap (`TapCnt == TAP_COUNT-1`) on accept:
  - Sum including this sample goes to the result register; `OutValid` is set and `OutOvf` is loaded.
  - Running sums, the internal overflow flags and `TapCnt` return to 0. The next window starts on the following accept.
- Result handshake: `OutData`/`OutOvf` stay stable while `OutValid && !OutReady`. `OutValid` clears on the edge where `OutReady` is high, unless that same edge loads a new result, in which case `OutValid` stays 1 with the new data.
- `InReady = !Clear && !(OutValid && !OutReady && TapCnt == TAP_COUNT-1)`.
  - Only the final tap stalls; earlier taps of the next window are always accepted.
  - There is a combinational path from `OutReady` to `InReady`.
- `Clear`:
  - Zeroes the running sums, internal overflow flags and `TapCnt`. Any sample presented that cycle is discarded (`InReady` is 0).
  - Does not affect `OutValid`, `OutData` or `OutOvf`.
- Arithmetic is signed two's complement at `WIDTH`. Overflow is signed overflow of any single add in the window.

## Timing
- Reset (async assert, outputs immediate):
  - `OutValid=0`, `OutData=0`, `OutOvf=0`, `TapCnt=0`.
  - `InReady` follows its equation, giving 1 when `Clear=0`.
  - Sums are 0.
- Reset asserted mid-window aborts the window and any pending result.
- Latency: the final tap accepted at edge N gives `OutValid=1` and a valid `OutData` immediately after edge N.
- Throughput: one sample per cycle sustained when `OutReady` is held high. One result every `TAP_COUNT` accepts.
- Clear and final tap in the same cycle: Clear wins, and no result is produced.

## Configuration
- `ACCUM_SAT_EN` defined:
  - Each add clamps to `2^(WIDTH-1)-1` or `-2^(WIDTH-1)`.
  - The channel's overflow flag sets and is sticky for the window.
  - The clamped value is the starting value for the next add.
- Undefined:
  - Adds wrap modulo `2^WIDTH`.
  - `OutOvf` is tied to 0 and the overflow logic is removed.

## Test plan
Bench configuration unless stated: `CHANNELS=2`, `TAP_COUNT=3`, `WIDTH=16`, `IN_WIDTH=8`.
- Reset check: assert `Reset` with no clock edge -> `OutValid=0`, `OutData=0`, `TapCnt=0`; `InReady=1` with `Clear=0`.
- Basic window: ch0 = 1,2,3, ch1 = -1,-2,-3 on consecutive cycles, `OutReady=1` -> after the third edge, `OutData` ch0=6, ch1=-6 (0xFFFA), `OutValid` high for 1 cycle.
- Backpressure:
  - Stimulus: `OutReady=0`; offer 6 samples of ch0=1.
  - `InReady` drops at the 6th sample while window 1 (ch0=3) is held.
  - Pulse `OutReady` -> the 6th sample is accepted on the same edge, and `OutData` ch0=3 from window 2 appears with `OutValid` still 1.
- Clear mid-window: accept 5, 5, then `Clear` with `InValid=1` -> sample discarded, `TapCnt=0`; then 1,1,1 -> ch0=3.
- Overflow (`WIDTH=8`): ch0 = 100,100,100 -> with `ACCUM_SAT_EN`, ch0=127 and `OutOvf[0]=1`; without it, ch0=44 and `OutOvf=0`.
- Async reset mid-window after 2 taps -> outputs zero without a clock edge. After release, a full window of 2,2,2 -> ch0=6.
